// File: rtl/video_pkg.sv
// video_pkg: shared pixel width, writer state encoding and {row,col} address packing
package video_pkg;

    localparam int RGB_W = 12;

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} wr_state_t;

    function automatic logic [31:0] pack_addr(input logic [31:0] row, input logic [31:0] col, input int unsigned col_bits);
        return (row << col_bits) | col;
    endfunction

endpackage

// File: rtl/raster_addr_counter.sv
// raster_addr_counter: column/row raster position with wrap, advance enable and sync clear
module raster_addr_counter #(
    parameter int WX = 8,
    parameter int WY = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [WY-1:0] row,
    output logic [WX-1:0] col,
    output logic          last_pos
);

    assign last_pos = &{row, col};

    // col steps every advance; row steps when col wraps, so the last pixel returns both to 0
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            col <= col + 1'b1;
            if (&col) row <= row + 1'b1;
        end

endmodule

// File: rtl/sprite_ram_writer.sv
// sprite_ram_writer: turns a raster pixel stream (or a clear request) into registered RAM writes
module sprite_ram_writer
    import video_pkg::*;
#(
    parameter int               ADDR_WIDTH_X = 8,
    parameter int               ADDR_WIDTH_Y = 7,
    parameter logic [RGB_W-1:0] CLEAR_COLOR  = 12'h000,
    localparam int              ADDR_WIDTH   = ADDR_WIDTH_X + ADDR_WIDTH_Y
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear_req,
    input  logic                  s_valid,
    input  logic [RGB_W-1:0]      s_pixel,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [RGB_W-1:0]      wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);

    wr_state_t               state, state_n;
    logic [ADDR_WIDTH_Y-1:0] row;
    logic [ADDR_WIDTH_X-1:0] col;
    logic                    last_pos, beat, fill, adv, fin, ctr_clr;

    raster_addr_counter #(.WX(ADDR_WIDTH_X), .WY(ADDR_WIDTH_Y)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (ctr_clr),
        .inc      (adv),
        .row      (row),
        .col      (col),
        .last_pos (last_pos)
    );

    // a load ends on the final position or an early s_last; clear wins over start in IDLE
    always_comb begin
        beat    = state == LOAD && s_valid && s_ready;
        fill    = state == CLEAR;
        adv     = beat || fill;
        fin     = (beat && (last_pos || s_last)) || (fill && last_pos);
        ctr_clr = state == IDLE || fin;
        state_n = state == IDLE ? (clear_req ? CLEAR : start ? LOAD : IDLE)
                : state == DONE ? IDLE
                : fin           ? DONE
                : state;
    end

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    // registered handshake, status and RAM write port
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            s_ready <= state_n == LOAD;
            busy    <= state_n == LOAD || state_n == CLEAR;
            done    <= state == DONE;
            wr_en   <= adv;
            if (adv) begin
                wr_addr <= ADDR_WIDTH'(pack_addr(32'(row), 32'(col), ADDR_WIDTH_X));
                wr_data <= fill ? CLEAR_COLOR : s_pixel;
            end
            if (state == IDLE && state_n == LOAD) frame_err <= 1'b0;
            else if (beat && (last_pos != s_last)) frame_err <= 1'b1;
        end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// tb_sprite_ram_writer: randomized stream checks of a 4x4 writer and a full-size default writer
module tb_sprite_ram_writer;

    typedef struct {int cyc; int addr; int data;} wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t mk(input int c, input int a, input int d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    logic        sm_rst, sm_start, sm_clr, sm_valid, sm_last;
    logic [11:0] sm_pixel, sm_data;
    logic        sm_ready, sm_wr_en, sm_busy, sm_done, sm_err;
    logic [3:0]  sm_addr;

    sprite_ram_writer #(.ADDR_WIDTH_X(2), .ADDR_WIDTH_Y(2), .CLEAR_COLOR(12'h5A3)) u_sm (
        .clk(clk), .reset(sm_rst), .start(sm_start), .clear_req(sm_clr),
        .s_valid(sm_valid), .s_pixel(sm_pixel), .s_last(sm_last), .s_ready(sm_ready),
        .wr_en(sm_wr_en), .wr_addr(sm_addr), .wr_data(sm_data),
        .busy(sm_busy), .done(sm_done), .frame_err(sm_err)
    );

    logic        bg_rst, bg_start, bg_clr, bg_valid, bg_last;
    logic [11:0] bg_pixel, bg_data;
    logic        bg_ready, bg_wr_en, bg_busy, bg_done, bg_err;
    logic [14:0] bg_addr;

    sprite_ram_writer u_bg (
        .clk(clk), .reset(bg_rst), .start(bg_start), .clear_req(bg_clr),
        .s_valid(bg_valid), .s_pixel(bg_pixel), .s_last(bg_last), .s_ready(bg_ready),
        .wr_en(bg_wr_en), .wr_addr(bg_addr), .wr_data(bg_data),
        .busy(bg_busy), .done(bg_done), .frame_err(bg_err)
    );

    wr_t sm_obs[$], sm_exp[$];
    int  sm_done_cyc[$];

    always @(negedge clk) begin
        if (sm_wr_en) sm_obs.push_back(mk(cyc, int'(sm_addr), int'(sm_data)));
        if (sm_done) sm_done_cyc.push_back(cyc);
    end

    logic [11:0] bg_q[$];
    int bg_n = 0, bg_bad = 0, bg_done_n = 0, bg_rst_wr = 0, bg_last_addr = 0;

    always @(negedge clk) begin
        if (bg_wr_en) begin
            if (bg_rst) bg_rst_wr++;
            if (bg_n >= bg_q.size() || int'(bg_addr) != bg_n || bg_data != bg_q[bg_n]) bg_bad++;
            bg_last_addr = int'(bg_addr);
            bg_n++;
        end
        if (bg_done) bg_done_n++;
    end

    // model: k-th accepted beat lands at raster address k one cycle later; frame ends at beat 16 or s_last
    task automatic sm_load(input int n, input int last_at, input bit gappy);
        bit hs;
        sm_obs.delete(); sm_exp.delete(); sm_done_cyc.delete();
        sm_start = 1'b1;
        tick;
        sm_start = 1'b0;
        check("sm_ready_after_start", sm_ready, 1);
        check("sm_busy_load", sm_busy, 1);
        check("sm_err_cleared", sm_err, 0);
        for (int k = 0; k < n; k++) begin
            if (gappy) repeat ($urandom_range(0, 2)) begin sm_valid = 1'b0; tick; end
            sm_valid = 1'b1;
            sm_pixel = 12'($urandom);
            sm_last  = (k == last_at - 1);
            hs = 1'b0;
            for (int t = 0; t < 20 && !hs; t++) begin hs = sm_ready; tick; end
            check("sm_hs_timeout", hs, 1);
            sm_exp.push_back(mk(cyc, k, int'(sm_pixel)));
        end
        sm_valid = 1'b0;
        sm_last  = 1'b0;
        check("sm_ready_drop", sm_ready, 0);
        repeat (4) tick;
        check("sm_nwr", sm_obs.size(), sm_exp.size());
        for (int i = 0; i < sm_obs.size() && i < sm_exp.size(); i++) begin
            check("sm_addr", sm_obs[i].addr, sm_exp[i].addr);
            check("sm_data", sm_obs[i].data, sm_exp[i].data);
            check("sm_wr_cyc", sm_obs[i].cyc, sm_exp[i].cyc);
        end
        check("sm_done_n", sm_done_cyc.size(), 1);
        if (sm_done_cyc.size() > 0 && sm_exp.size() > 0)
            check("sm_done_cyc", sm_done_cyc[0], sm_exp[sm_exp.size()-1].cyc + 1);
        check("sm_err", sm_err, last_at != 16);
        check("sm_busy_end", sm_busy, 0);
    endtask

    task automatic bg_load(input int n, input bit with_last);
        bit hs;
        bg_n = 0; bg_bad = 0; bg_done_n = 0;
        bg_q.delete();
        bg_start = 1'b1;
        tick;
        bg_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            bg_valid = 1'b1;
            bg_pixel = 12'($urandom);
            bg_last  = with_last && (k == n - 1);
            bg_q.push_back(bg_pixel);
            hs = 1'b0;
            for (int t = 0; t < 10 && !hs; t++) begin hs = bg_ready; tick; end
            if (!hs) check("bg_hs_timeout", hs, 1);
        end
        bg_valid = 1'b0;
        bg_last  = 1'b0;
    endtask

    initial begin
        int c0, rdy_hi;
        sm_rst = 1'b1; sm_start = 1'b0; sm_clr = 1'b0; sm_valid = 1'b0; sm_last = 1'b0; sm_pixel = '0;
        bg_rst = 1'b1; bg_start = 1'b0; bg_clr = 1'b0; bg_valid = 1'b0; bg_last = 1'b0; bg_pixel = '0;
        repeat (2) tick;
        check("sm_rst_flags", {sm_ready, sm_wr_en, sm_busy, sm_done, sm_err}, 0);
        check("sm_rst_addr_data", {sm_addr, sm_data}, 0);
        check("bg_rst_flags", {bg_ready, bg_wr_en, bg_busy, bg_done, bg_err}, 0);
        sm_rst = 1'b0;
        bg_rst = 1'b0;
        tick;

        sm_load(16, 16, 1'b0);
        sm_load(16, 16, 1'b1);
        sm_load(5, 5, 1'b0);
        sm_load(16, 16, 1'b1);
        sm_load(16, 0, 1'b0);

        sm_obs.delete(); sm_done_cyc.delete();
        sm_start = 1'b1; sm_clr = 1'b1;
        tick;
        c0 = cyc;
        sm_valid = 1'b1; sm_pixel = 12'hFFF;
        rdy_hi = 0;
        for (int t = 0; t < 24; t++) begin
            sm_start = (t == 3 || t == 9);
            sm_clr   = (t == 3 || t == 9);
            if (sm_ready) rdy_hi++;
            tick;
        end
        sm_start = 1'b0; sm_clr = 1'b0; sm_valid = 1'b0;
        check("clr_nwr", sm_obs.size(), 16);
        for (int i = 0; i < sm_obs.size() && i < 16; i++) begin
            check("clr_addr", sm_obs[i].addr, i);
            check("clr_data", sm_obs[i].data, 12'h5A3);
            check("clr_cyc", sm_obs[i].cyc, c0 + 1 + i);
        end
        check("clr_ready", rdy_hi, 0);
        check("clr_done_n", sm_done_cyc.size(), 1);
        if (sm_done_cyc.size() > 0) check("clr_done_cyc", sm_done_cyc[0], c0 + 17);
        check("clr_busy_end", sm_busy, 0);

        bg_load(3 * 256 + 10, 1'b0);
        bg_rst = 1'b1;
        #1;
        check("bg_midrst_flags", {bg_ready, bg_wr_en, bg_busy, bg_done, bg_err}, 0);
        check("bg_midrst_addr", bg_addr, 0);
        check("bg_midrst_data", bg_data, 0);
        bg_valid = 1'b1;
        repeat (3) tick;
        bg_rst = 1'b0;
        repeat (3) tick;
        check("bg_rst_ready_idle", bg_ready, 0);
        bg_valid = 1'b0;
        check("bg_rst_wr", bg_rst_wr, 0);
        check("bg_pre_rst_writes", bg_n, 3 * 256 + 9);
        check("bg_pre_rst_bad", bg_bad, 0);

        bg_load(32768, 1'b1);
        repeat (4) tick;
        check("bg_full_n", bg_n, 32768);
        check("bg_full_bad", bg_bad, 0);
        check("bg_full_last", bg_last_addr, 15'h7FFF);
        check("bg_full_done", bg_done_n, 1);
        check("bg_full_busy", bg_busy, 0);
        check("bg_full_err", bg_err, 0);

        bg_load(1, 1'b1);
        repeat (4) tick;
        check("bg_wrap_n", bg_n, 1);
        check("bg_wrap_addr", bg_bad, 0);
        check("bg_wrap_err", bg_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
